// File: rtl/fpfma_pkg.sv
// Shared FMA datapath package: width constants and a constant-foldable clog2.
// Consumers: lza_pipe, lza_penc.
package fpfma_pkg;

    localparam int unsigned SIG_WIDTH = 23;
    // Aligned-addend width feeding the leading-zero anticipator.
    localparam int unsigned LZA_WIDTH = 2 * (SIG_WIDTH + 1) + 2;

    // Ceiling log2, usable in parameter defaults.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = 1; v < n; v = v << 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lza_penc.sv
// Combinational priority encoder: index of the highest set bit of i_vec,
// built as a log-depth binary tree over the vector zero-padded to 2**CNT_W.
// Ports:
//   i_vec  [WIDTH]  input vector (caller guarantees at least one set bit)
//   o_pos  [CNT_W]  index of the highest set bit
module lza_penc
    import fpfma_pkg::*;
#(
    parameter int unsigned WIDTH = LZA_WIDTH,
    parameter int unsigned CNT_W = clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] i_vec,
    output logic [CNT_W-1:0] o_pos
);

    localparam int unsigned P = 32'd1 << CNT_W;

    logic [P-1:0]     w_vld [CNT_W+1];
    logic [CNT_W-1:0] w_idx [CNT_W+1][P];

    // Each level merges node pairs; the upper child wins and contributes bit l.
    always_comb begin
        for (int l = 0; l <= int'(CNT_W); l++) begin
            w_vld[l] = '0;
            for (int k = 0; k < int'(P); k++) begin
                w_idx[l][k] = '0;
            end
        end
        w_vld[0] = P'(i_vec);
        for (int l = 0; l < int'(CNT_W); l++) begin
            for (int k = 0; k < int'(P >> (l + 1)); k++) begin
                w_vld[l+1][k] = w_vld[l][2*k+1] | w_vld[l][2*k];
                w_idx[l+1][k] = w_vld[l][2*k+1] ? (w_idx[l][2*k+1] | CNT_W'(32'd1 << l))
                                                : w_idx[l][2*k];
            end
        end
    end

    assign o_pos = w_idx[CNT_W][0];

endmodule

// File: rtl/lza_pipe.sv
// Two-stage pipelined leading-zero anticipator for the FMA normalisation path.
// S1 registers the G/T/Z indicator vector f; S2 priority-encodes it into a
// normalisation shift count. Valid/ready handshake on both sides.
// Optional macro LZA_PIPE_CORRECT_EN adds an adder in S1 and a one-bit
// correction in S2 so ld_count is exact; without it ld_count may be one high.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake
//   op_a, op_b [WIDTH]    aligned two's-complement addends
//   out_valid / out_ready result handshake
//   ld_count [CNT_W]      normalisation shift amount
//   no_ind                f[WIDTH-1:1] was all zero
//   corr                  correction applied (0 when the feature is off)
module lza_pipe
    import fpfma_pkg::*;
#(
    parameter int unsigned WIDTH = LZA_WIDTH,
    parameter int unsigned CNT_W = clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] ld_count,
    output logic             no_ind,
    output logic             corr
);

    logic [WIDTH-1:0] w_g, w_t, w_z, w_f;
    logic             w_adv2;
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_f;
    logic [CNT_W-1:0] w_pos, w_raw, w_cnt;
    logic             w_no_ind, w_corr;
    logic             r_out_valid;
    logic [CNT_W-1:0] r_ld_count;
    logic             r_no_ind, r_corr;

    assign w_g = op_a & op_b;
    assign w_t = op_a ^ op_b;
    assign w_z = ~op_a & ~op_b;

    // Indicator vector; f[0] is a sentinel so the encoder always finds a bit.
    always_comb begin
        w_f = '0;
        w_f[WIDTH-1] = ~w_t[WIDTH-1] & w_t[WIDTH-2];
        for (int j = int'(WIDTH) - 2; j >= 1; j--) begin
            w_f[j] = (w_t[j+1] & ((w_g[j] & ~w_z[j-1]) | (w_z[j] & ~w_g[j-1])))
                   | (~w_t[j+1] & ((w_z[j] & ~w_z[j-1]) | (w_g[j] & ~w_g[j-1])));
        end
        w_f[0] = 1'b1;
    end

    // S2 frees when empty or draining; S1 accepts when empty or S2 frees.
    assign w_adv2   = ~r_out_valid | out_ready;
    assign in_ready = ~r_s1_valid | w_adv2;

    // S1: indicator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_f        <= '0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_f <= w_f;
            end
        end
    end

    lza_penc #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_penc (
        .i_vec (r_f),
        .o_pos (w_pos)
    );

    assign w_raw    = CNT_W'(WIDTH - 1) - w_pos;
    assign w_no_ind = (w_pos == '0);

`ifdef LZA_PIPE_CORRECT_EN
    logic [WIDTH-1:0] r_sum;

    // S1: true sum, used to detect the one-position overshoot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= '0;
        end else if (in_ready && in_valid) begin
            r_sum <= op_a + op_b;
        end
    end

    // Bit at pos already differs from the sign: the anticipator overshot by one.
    assign w_corr = (w_raw != '0) && (r_sum[w_pos] != r_sum[WIDTH-1]);
    assign w_cnt  = w_corr ? (w_raw - CNT_W'(1)) : w_raw;
`else
    assign w_corr = 1'b0;
    assign w_cnt  = w_raw;
`endif

    // S2: result register, held while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_ld_count  <= '0;
            r_no_ind    <= 1'b0;
            r_corr      <= 1'b0;
        end else if (w_adv2) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_ld_count <= w_cnt;
                r_no_ind   <= w_no_ind;
                r_corr     <= w_corr;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign ld_count  = r_ld_count;
    assign no_ind    = r_no_ind;
    assign corr      = r_corr;

endmodule

// File: tb/tb_lza_pipe.sv
// Directed bench for lza_pipe: an 8-bit and a 50-bit instance share clk/rst_n.
// Inputs are driven and outputs sampled on the falling edge.
module tb_lza_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       iv8, ir8, ov8, or8, ni8, c8;
    logic [7:0] a8, b8;
    logic [2:0] cnt8;

    logic        iv50, ir50, ov50, or50, ni50, c50;
    logic [49:0] a50, b50;
    logic [5:0]  cnt50;

    int checks = 0;
    int errors = 0;

`ifdef LZA_PIPE_CORRECT_EN
    localparam logic [2:0] EXP53_CNT  = 3'd3;
    localparam logic       EXP53_CORR = 1'b1;
`else
    localparam logic [2:0] EXP53_CNT  = 3'd4;
    localparam logic       EXP53_CORR = 1'b0;
`endif

    lza_pipe #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .op_a(a8), .op_b(b8), .out_valid(ov8), .out_ready(or8),
        .ld_count(cnt8), .no_ind(ni8), .corr(c8)
    );

    lza_pipe #(.WIDTH(50)) u50 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv50), .in_ready(ir50),
        .op_a(a50), .op_b(b50), .out_valid(ov50), .out_ready(or50),
        .ld_count(cnt50), .no_ind(ni50), .corr(c50)
    );

    // Count of bits below the sign of (a+b) mod 256 that equal the sign.
    function automatic int exact_cnt8(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] s;
        int         e;
        logic       run;
        s   = a + b;
        e   = 0;
        run = 1'b1;
        for (int i = 6; i >= 0; i--) begin
            if (run && (s[i] == s[7])) e++;
            else run = 1'b0;
        end
        return e;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        iv8 = 1'b0; a8 = '0; b8 = '0; or8 = 1'b1;
        iv50 = 1'b0; a50 = '0; b50 = '0; or50 = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (ov8 !== 1'b0)   begin errors++; $display("FAIL reset_ov8 got %b want 0", ov8); end
        checks++; if (cnt8 !== 3'd0)  begin errors++; $display("FAIL reset_cnt8 got %0d want 0", cnt8); end
        checks++; if (ni8 !== 1'b0)   begin errors++; $display("FAIL reset_ni8 got %b want 0", ni8); end
        checks++; if (c8 !== 1'b0)    begin errors++; $display("FAIL reset_c8 got %b want 0", c8); end
        checks++; if (ov50 !== 1'b0)  begin errors++; $display("FAIL reset_ov50 got %b want 0", ov50); end
        checks++; if (cnt50 !== 6'd0) begin errors++; $display("FAIL reset_cnt50 got %0d want 0", cnt50); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (ir8 !== 1'b1)   begin errors++; $display("FAIL reset_ir8 got %b want 1", ir8); end
        checks++; if (ir50 !== 1'b1)  begin errors++; $display("FAIL reset_ir50 got %b want 1", ir50); end
    endtask

    task automatic test_basic8();
        logic [7:0] ta [2];
        logic [7:0] tb [2];
        logic [2:0] tc [2];
        logic       tr [2];
        ta[0] = 8'h01; tb[0] = 8'h00; tc[0] = 3'd6;      tr[0] = 1'b0;
        ta[1] = 8'h05; tb[1] = 8'h03; tc[1] = EXP53_CNT; tr[1] = EXP53_CORR;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            a8 = ta[i]; b8 = tb[i]; iv8 = 1'b1; or8 = 1'b1;
            @(negedge clk);
            iv8 = 1'b0;
            checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL basic8_lat1[%0d] got %b want 0", i, ov8); end
            @(negedge clk);
            checks++; if (ov8 !== 1'b1)  begin errors++; $display("FAIL basic8_valid[%0d] got %b want 1", i, ov8); end
            checks++; if (cnt8 !== tc[i]) begin errors++; $display("FAIL basic8_cnt[%0d] got %0d want %0d", i, cnt8, tc[i]); end
            checks++; if (ni8 !== 1'b0)  begin errors++; $display("FAIL basic8_noind[%0d] got %b want 0", i, ni8); end
            checks++; if (c8 !== tr[i])  begin errors++; $display("FAIL basic8_corr[%0d] got %b want %b", i, c8, tr[i]); end
        end
    endtask

    task automatic test_w50();
        @(negedge clk);
        a50 = 50'(1) << 48; b50 = '0; iv50 = 1'b1; or50 = 1'b1;
        @(negedge clk);
        a50 = '0; b50 = '0;
        @(negedge clk);
        iv50 = 1'b0;
        checks++; if (ov50 !== 1'b1)  begin errors++; $display("FAIL w50_top_valid got %b want 1", ov50); end
        checks++; if (cnt50 !== 6'd0) begin errors++; $display("FAIL w50_top_cnt got %0d want 0", cnt50); end
        checks++; if (ni50 !== 1'b0)  begin errors++; $display("FAIL w50_top_noind got %b want 0", ni50); end
        @(negedge clk);
        checks++; if (ov50 !== 1'b1)   begin errors++; $display("FAIL w50_zero_valid got %b want 1", ov50); end
        checks++; if (cnt50 !== 6'd49) begin errors++; $display("FAIL w50_zero_cnt got %0d want 49", cnt50); end
        checks++; if (ni50 !== 1'b1)   begin errors++; $display("FAIL w50_zero_noind got %b want 1", ni50); end
        checks++; if (c50 !== 1'b0)    begin errors++; $display("FAIL w50_zero_corr got %b want 0", c50); end
        @(negedge clk);
        checks++; if (ov50 !== 1'b0)   begin errors++; $display("FAIL w50_drain got %b want 0", ov50); end
    endtask

    // Positive operands with leading one at k (b=0): exact count 48-k in both builds.
    task automatic test_back_to_back();
        int          q[$];
        int          sent, prev_k, k, cyc, e;
        logic        hold, exp_ir;
        logic [5:0]  held_cnt;
        logic        held_ni, held_c;
        logic [49:0] rnd;
        sent = 0; prev_k = -1; k = 0; cyc = 0; hold = 1'b0;
        held_cnt = '0; held_ni = 1'b0; held_c = 1'b0;
        iv50 = 1'b0; or50 = 1'b1;
        while ((sent < 20 || q.size() != 0) && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (hold) begin
                checks++;
                if (ov50 !== 1'b1 || cnt50 !== held_cnt || ni50 !== held_ni || c50 !== held_c) begin
                    errors++;
                    $display("FAIL b2b_stall_hold got v=%b c=%0d want v=1 c=%0d", ov50, cnt50, held_cnt);
                end
            end
            or50 = 1'($urandom_range(0, 1));
            if (sent < 20) begin
                iv50 = ($urandom_range(0, 3) != 0);
                k = $urandom_range(0, 47);
                while (k == prev_k) k = $urandom_range(0, 47);
                rnd = 50'({$urandom, $urandom});
                a50 = (50'(1) << k) | (rnd & ((50'(1) << k) - 50'(1)));
                b50 = '0;
            end else begin
                iv50 = 1'b0;
            end
            #1;
            exp_ir = !(q.size() == 2 && !or50);
            checks++;
            if (ir50 !== exp_ir) begin
                errors++;
                $display("FAIL b2b_in_ready got %b want %b", ir50, exp_ir);
            end
            if (ov50 && or50) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_spurious got cnt=%0d want no output", cnt50);
                end else begin
                    e = q.pop_front();
                    if (cnt50 !== 6'(e) || ni50 !== 1'b0 || c50 !== 1'b0) begin
                        errors++;
                        $display("FAIL b2b_result got %0d/%b/%b want %0d/0/0", cnt50, ni50, c50, e);
                    end
                end
            end
            hold     = ov50 && !or50;
            held_cnt = cnt50; held_ni = ni50; held_c = c50;
            if (iv50 && ir50) begin
                q.push_back(48 - k);
                prev_k = k;
                sent++;
            end
        end
        iv50 = 1'b0; or50 = 1'b1;
        checks++;
        if (sent != 20 || q.size() != 0) begin
            errors++;
            $display("FAIL b2b_complete got sent=%0d pending=%0d want 20/0", sent, q.size());
        end
    endtask

    task automatic test_reset_mid_stall();
        @(negedge clk);
        or50 = 1'b0; a50 = '0; b50 = '0; iv50 = 1'b1;
        @(negedge clk);
        a50 = 50'(1) << 20;
        @(negedge clk);
        iv50 = 1'b0;
        #1;
        checks++; if (ir50 !== 1'b0)   begin errors++; $display("FAIL mid_full_ready got %b want 0", ir50); end
        checks++; if (ov50 !== 1'b1)   begin errors++; $display("FAIL mid_full_valid got %b want 1", ov50); end
        checks++; if (cnt50 !== 6'd49) begin errors++; $display("FAIL mid_full_cnt got %0d want 49", cnt50); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (ov50 !== 1'b0)  begin errors++; $display("FAIL mid_rst_valid got %b want 0", ov50); end
        checks++; if (cnt50 !== 6'd0) begin errors++; $display("FAIL mid_rst_cnt got %0d want 0", cnt50); end
        checks++; if (ni50 !== 1'b0)  begin errors++; $display("FAIL mid_rst_noind got %b want 0", ni50); end
        checks++; if (c50 !== 1'b0)   begin errors++; $display("FAIL mid_rst_corr got %b want 0", c50); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (ir50 !== 1'b1)  begin errors++; $display("FAIL mid_rel_ready got %b want 1", ir50); end
        or50 = 1'b1; a50 = 50'(1) << 10; b50 = '0; iv50 = 1'b1;
        @(negedge clk);
        iv50 = 1'b0;
        checks++; if (ov50 !== 1'b0)   begin errors++; $display("FAIL mid_lat1 got %b want 0", ov50); end
        @(negedge clk);
        checks++; if (ov50 !== 1'b1)   begin errors++; $display("FAIL mid_new_valid got %b want 1", ov50); end
        checks++; if (cnt50 !== 6'd38) begin errors++; $display("FAIL mid_new_cnt got %0d want 38", cnt50); end
        @(negedge clk);
        checks++; if (ov50 !== 1'b0)   begin errors++; $display("FAIL mid_no_stale got %b want 0", ov50); end
    endtask

    // Every 8-bit pair streamed at full rate; result for pair n-2 seen at step n.
    task automatic test_sweep8();
        or8 = 1'b1;
        for (int n = 0; n < 65538; n++) begin
            @(negedge clk);
            if (n >= 2) begin
                int         m, e, c;
                logic [7:0] pa, pb;
                m  = n - 2;
                pa = 8'(m >> 8);
                pb = 8'(m);
                e  = exact_cnt8(pa, pb);
                c  = int'(cnt8);
                checks++;
`ifdef LZA_PIPE_CORRECT_EN
                if (ov8 !== 1'b1 || c != e) begin
`else
                if (ov8 !== 1'b1 || !(c == e || c == e + 1)) begin
`endif
                    errors++;
                    $display("FAIL sweep8 a=%h b=%h got v=%b cnt=%0d want exact=%0d", pa, pb, ov8, cnt8, e);
                end
            end
            if (n < 65536) begin
                a8 = 8'(n >> 8); b8 = 8'(n); iv8 = 1'b1;
            end else begin
                iv8 = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic8();
        test_w50();
        test_back_to_back();
        test_reset_mid_stall();
        test_sweep8();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
